contador_programa: RTL and testbench

- Program counter and next-address stage of the single-cycle datapath; it consumes the 32-bit jump target produced by the 26-to-32 jump-address extender.
- Holds the current instruction word address (word-addressed instruction memory, so sequential step is +1).
- Selects the next address from sequential, branch, jump or jump-register.
- Implements a small run/halt state machine and a retired-instruction counter.

---
 rtl/contador_programa.sv | 140 ++++++++++++++
 tb/tb_contador_programa.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/contador_programa.sv
// ---------------------------------------------------------------------------
// contador_programa
//
// Program counter and next-address stage of the single-cycle datapath.
// Instruction memory is word addressed, so a sequential step is +1. The next
// address comes from one of four sources: sequential, branch (pc+1+offset),
// absolute jump (target from the 26-to-32 jump-address extender) or jump to
// register. A small run/halt FSM gates advancement, and a saturating counter
// records how many times the PC advanced.
//
// habilita is a plain per-cycle enable, not a handshake. When it is high in
// EXECUTANDO, the inputs present at the rising edge take effect on that edge.
// When it is low, nothing changes. No back-pressure is signalled.
//
// Ports:
//   clock          in   rising-edge clock
//   reset          in   asynchronous, active-low reset
//   habilita       in   advance PC this cycle (0 = stall)
//   desvio         in   conditional branch taken
//   offset_desvio  in   LARGURA  signed word offset, already sign-extended
//   salto          in   absolute jump (j/jal)
//   alvo_salto     in   LARGURA  absolute jump target
//   salto_reg      in   jump to register (jr)
//   endereco_reg   in   LARGURA  register value for jr
//   parar          in   halt instruction decoded
//   continuar      in   resume from halt
//   pc             out  LARGURA  current instruction address (registered)
//   pc_mais_um     out  LARGURA  pc+1, link value for jal (combinational)
//   parado         out  high while halted (registered)
//   estado         out  2        FSM state: INICIO=0, EXECUTANDO=1, PARADO=2
//   instrucoes     out  LARGURA_CONT  saturating count of PC advances
// ---------------------------------------------------------------------------
module contador_programa #(
    parameter int unsigned LARGURA      = 32,
    parameter int unsigned PC_INICIAL   = 0,
    parameter int unsigned LARGURA_CONT = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    habilita,
    input  logic                    desvio,
    input  logic [LARGURA-1:0]      offset_desvio,
    input  logic                    salto,
    input  logic [LARGURA-1:0]      alvo_salto,
    input  logic                    salto_reg,
    input  logic [LARGURA-1:0]      endereco_reg,
    input  logic                    parar,
    input  logic                    continuar,
    output logic [LARGURA-1:0]      pc,
    output logic [LARGURA-1:0]      pc_mais_um,
    output logic                    parado,
    output logic [1:0]              estado,
    output logic [LARGURA_CONT-1:0] instrucoes
);

    typedef enum logic [1:0] {
        INICIO     = 2'd0,
        EXECUTANDO = 2'd1,
        PARADO     = 2'd2
    } estado_t;

    localparam logic [LARGURA-1:0] PC_RESET = LARGURA'(PC_INICIAL);

    estado_t                 estado_q;
    logic [LARGURA-1:0]      pc_q;
    logic                    parado_q;
    logic [LARGURA_CONT-1:0] cont_q;

    logic [LARGURA-1:0]      proximo_pc;
    logic [LARGURA_CONT-1:0] cont_sat;

    // All PC arithmetic wraps modulo 2^LARGURA. This is the natural
    // truncation of the sums.
    assign pc_mais_um = pc_q + LARGURA'(1);

    // The counter sticks at all-ones rather than wrapping back to zero.
    assign cont_sat = (cont_q == '1) ? cont_q : cont_q + LARGURA_CONT'(1);

    // Next-address select. The priority order is jr, then j, then branch,
    // then sequential. A negative offset simply wraps below zero.
    always_comb begin
        proximo_pc = pc_mais_um;
        if (salto_reg) begin
            proximo_pc = endereco_reg;
        end else if (salto) begin
            proximo_pc = alvo_salto;
        end else if (desvio) begin
            proximo_pc = pc_mais_um + offset_desvio;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= INICIO;
            pc_q     <= PC_RESET;
            parado_q <= 1'b0;
            cont_q   <= '0;
        end else begin
            case (estado_q)
                // One settling cycle after reset. All inputs are ignored.
                INICIO: begin
                    estado_q <= EXECUTANDO;
                end
                EXECUTANDO: begin
                    if (habilita) begin
                        if (parar) begin
                            // A halt does not retire an advance, so the PC
                            // and the counter both hold.
                            estado_q <= PARADO;
                            parado_q <= 1'b1;
                        end else begin
                            pc_q   <= proximo_pc;
                            cont_q <= cont_sat;
                        end
                    end
                end
                PARADO: begin
                    // Only continuar is observed here. It takes precedence
                    // over a still-asserted parar.
                    if (continuar) begin
                        pc_q     <= pc_mais_um;
                        cont_q   <= cont_sat;
                        estado_q <= EXECUTANDO;
                        parado_q <= 1'b0;
                    end
                end
                default: begin
                    estado_q <= INICIO;
                    parado_q <= 1'b0;
                end
            endcase
        end
    end

    assign pc         = pc_q;
    assign parado     = parado_q;
    assign estado     = estado_q;
    assign instrucoes = cont_q;

endmodule

// File: tb/tb_contador_programa.sv
module tb_contador_programa;

    logic        clock;
    logic        reset;
    logic        habilita;
    logic        desvio;
    logic [31:0] offset_desvio;
    logic        salto;
    logic [31:0] alvo_salto;
    logic        salto_reg;
    logic [31:0] endereco_reg;
    logic        parar;
    logic        continuar;
    logic [31:0] pc;
    logic [31:0] pc_mais_um;
    logic        parado;
    logic [1:0]  estado;
    logic [15:0] instrucoes;

    int checks = 0;
    int errors = 0;

    // Scoreboard: expected pc / counter pushed when stimulus is driven,
    // popped after the edge that applies it.
    logic [31:0] exp_q[$];
    logic [15:0] exp_cnt_q[$];
    logic [31:0] pc_m;
    logic [15:0] cnt_m;
    logic [31:0] exp_pc;
    logic [15:0] exp_cnt;

    contador_programa #(
        .LARGURA(32),
        .PC_INICIAL(0),
        .LARGURA_CONT(16)
    ) dut (
        .clock(clock),
        .reset(reset),
        .habilita(habilita),
        .desvio(desvio),
        .offset_desvio(offset_desvio),
        .salto(salto),
        .alvo_salto(alvo_salto),
        .salto_reg(salto_reg),
        .endereco_reg(endereco_reg),
        .parar(parar),
        .continuar(continuar),
        .pc(pc),
        .pc_mais_um(pc_mais_um),
        .parado(parado),
        .estado(estado),
        .instrucoes(instrucoes)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic h, input logic d, input logic [31:0] off,
                         input logic s, input logic [31:0] alvo,
                         input logic sr, input logic [31:0] er,
                         input logic p, input logic c);
        habilita      = h;
        desvio        = d;
        offset_desvio = off;
        salto         = s;
        alvo_salto    = alvo;
        salto_reg     = sr;
        endereco_reg  = er;
        parar         = p;
        continuar     = c;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Jump to an address and account for the advance in the models.
    task automatic goto_addr(input logic [31:0] a);
        drive(1, 0, 0, 1, a, 0, 0, 0, 0);
        tick();
        pc_m  = a;
        cnt_m = cnt_m + 1;
        checks++;
        if (pc !== a) begin
            errors++;
            $display("FAIL goto: pc=%h expected %h", pc, a);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        #1;
        checks++;
        if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc: pc=%h expected 0", pc); end
        checks++;
        if (pc_mais_um !== 32'h1) begin errors++; $display("FAIL reset_pc1: pc_mais_um=%h expected 1", pc_mais_um); end
        checks++;
        if (estado !== 2'd0 || parado !== 1'b0 || instrucoes !== 16'h0) begin
            errors++;
            $display("FAIL reset_state: estado=%0d parado=%b instr=%0d expected 0 0 0", estado, parado, instrucoes);
        end
        #7;
        reset = 1'b1;  // released between edges
        pc_m  = 0;
        cnt_m = 0;
    endtask

    task automatic test_sequential();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        // INICIO edge: pc holds at 0
        exp_q.push_back(32'h0); exp_cnt_q.push_back(16'd0);
        exp_q.push_back(32'h1); exp_cnt_q.push_back(16'd1);
        exp_q.push_back(32'h2); exp_cnt_q.push_back(16'd2);
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_pc  = exp_q.pop_front();
            exp_cnt = exp_cnt_q.pop_front();
            checks++;
            if (pc !== exp_pc || instrucoes !== exp_cnt) begin
                errors++;
                $display("FAIL seq[%0d]: pc=%h instr=%0d expected %h %0d", i, pc, instrucoes, exp_pc, exp_cnt);
            end
            checks++;
            if (estado !== 2'd1) begin errors++; $display("FAIL seq_estado[%0d]: estado=%0d expected 1", i, estado); end
        end
        pc_m  = 2;
        cnt_m = 2;
    endtask

    task automatic test_branch();
        goto_addr(32'd5);
        drive(1, 1, 32'hFFFF_FFFD, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(32'd3);
        tick();
        cnt_m = cnt_m + 1;
        exp_pc = exp_q.pop_front();
        checks++;
        if (pc !== exp_pc || instrucoes !== cnt_m) begin
            errors++;
            $display("FAIL branch_neg: pc=%h instr=%0d expected %h %0d", pc, instrucoes, exp_pc, cnt_m);
        end
        goto_addr(32'd5);
        drive(1, 1, 32'd4, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(32'd10);
        tick();
        cnt_m = cnt_m + 1;
        exp_pc = exp_q.pop_front();
        checks++;
        if (pc !== exp_pc) begin errors++; $display("FAIL branch_pos: pc=%h expected %h", pc, exp_pc); end
        pc_m = 32'd10;
    endtask

    task automatic test_jump_priority();
        goto_addr(32'd7);
        drive(1, 1, 32'd4, 1, 32'h03FF_FFFF, 0, 0, 0, 0);
        exp_q.push_back(32'h03FF_FFFF);
        tick();
        exp_pc = exp_q.pop_front();
        checks++;
        if (pc !== exp_pc) begin errors++; $display("FAIL jump_over_branch: pc=%h expected %h", pc, exp_pc); end
        drive(1, 0, 0, 1, 32'h1234, 1, 32'h40, 0, 0);
        exp_q.push_back(32'h40);
        tick();
        exp_pc = exp_q.pop_front();
        checks++;
        if (pc !== exp_pc) begin errors++; $display("FAIL jr_over_jump: pc=%h expected %h", pc, exp_pc); end
        checks++;
        if (pc_mais_um !== 32'h41) begin errors++; $display("FAIL link: pc_mais_um=%h expected 41", pc_mais_um); end
        cnt_m = cnt_m + 2;
        pc_m  = 32'h40;
        checks++;
        if (instrucoes !== cnt_m) begin errors++; $display("FAIL jump_cnt: instr=%0d expected %0d", instrucoes, cnt_m); end
    endtask

    task automatic test_halt();
        goto_addr(32'h20);
        drive(1, 0, 0, 1, 32'h999, 0, 0, 1, 0);
        tick();
        checks++;
        if (pc !== 32'h20 || parado !== 1'b1 || estado !== 2'd2 || instrucoes !== cnt_m) begin
            errors++;
            $display("FAIL halt: pc=%h parado=%b estado=%0d instr=%0d expected 20 1 2 %0d", pc, parado, estado, instrucoes, cnt_m);
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                  1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom, 0, 0);
            tick();
            checks++;
            if (pc !== 32'h20 || estado !== 2'd2 || instrucoes !== cnt_m) begin
                errors++;
                $display("FAIL halt_hold[%0d]: pc=%h estado=%0d instr=%0d expected 20 2 %0d", i, pc, estado, instrucoes, cnt_m);
            end
        end
        // parar still high: continuar must win
        drive(1, 0, 0, 1, 32'h999, 0, 0, 1, 1);
        exp_q.push_back(32'h21);
        tick();
        cnt_m  = cnt_m + 1;
        exp_pc = exp_q.pop_front();
        checks++;
        if (pc !== exp_pc || estado !== 2'd1 || parado !== 1'b0 || instrucoes !== cnt_m) begin
            errors++;
            $display("FAIL resume: pc=%h estado=%0d parado=%b instr=%0d expected %h 1 0 %0d", pc, estado, parado, instrucoes, exp_pc, cnt_m);
        end
        pc_m = 32'h21;
    endtask

    task automatic test_wrap_and_stall();
        goto_addr(32'hFFFF_FFFF);
        checks++;
        if (pc_mais_um !== 32'h0) begin errors++; $display("FAIL wrap_pc1: pc_mais_um=%h expected 0", pc_mais_um); end
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        exp_q.push_back(32'h0);
        tick();
        cnt_m  = cnt_m + 1;
        exp_pc = exp_q.pop_front();
        checks++;
        if (pc !== exp_pc) begin errors++; $display("FAIL wrap: pc=%h expected %h", pc, exp_pc); end
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 32'd8, 0, 0, 0, 0, 1, 0);
            tick();
            checks++;
            if (pc !== 32'h0 || instrucoes !== cnt_m || estado !== 2'd1) begin
                errors++;
                $display("FAIL stall[%0d]: pc=%h instr=%0d estado=%0d expected 0 %0d 1", i, pc, instrucoes, estado, cnt_m);
            end
        end
        pc_m = 32'h0;
    endtask

    task automatic test_back_to_back();
        logic        h, d, s, sr;
        logic [31:0] off, alvo, er;
        for (int i = 0; i < 24; i++) begin
            h    = ($urandom_range(0, 3) != 0);
            d    = 1'($urandom_range(0, 1));
            s    = ($urandom_range(0, 3) == 0);
            sr   = ($urandom_range(0, 4) == 0);
            off  = $urandom;
            alvo = $urandom;
            er   = $urandom;
            drive(h, d, off, s, alvo, sr, er, 0, 0);
            if (!h)      exp_pc = pc_m;
            else if (sr) exp_pc = er;
            else if (s)  exp_pc = alvo;
            else if (d)  exp_pc = pc_m + 32'd1 + off;
            else         exp_pc = pc_m + 32'd1;
            exp_q.push_back(exp_pc);
            exp_cnt_q.push_back(h ? cnt_m + 16'd1 : cnt_m);
            tick();
            exp_pc  = exp_q.pop_front();
            exp_cnt = exp_cnt_q.pop_front();
            checks++;
            if (pc !== exp_pc || instrucoes !== exp_cnt) begin
                errors++;
                $display("FAIL b2b[%0d]: pc=%h instr=%0d expected %h %0d", i, pc, instrucoes, exp_pc, exp_cnt);
            end
            pc_m  = exp_pc;
            cnt_m = exp_cnt;
        end
    endtask

    task automatic test_saturation();
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        while (cnt_m != 16'hFFFF) begin
            tick();
            cnt_m = cnt_m + 1;
            pc_m  = pc_m + 1;
        end
        checks++;
        if (instrucoes !== 16'hFFFF || pc !== pc_m) begin
            errors++;
            $display("FAIL sat_reach: pc=%h instr=%h expected %h ffff", pc, instrucoes, pc_m);
        end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(pc_m + 32'd1);
            exp_cnt_q.push_back(16'hFFFF);
            tick();
            exp_pc  = exp_q.pop_front();
            exp_cnt = exp_cnt_q.pop_front();
            checks++;
            if (pc !== exp_pc || instrucoes !== exp_cnt) begin
                errors++;
                $display("FAIL sat_hold[%0d]: pc=%h instr=%h expected %h %h", i, pc, instrucoes, exp_pc, exp_cnt);
            end
            pc_m = exp_pc;
        end
    endtask

    task automatic test_async_reset();
        goto_addr(32'h55);
        drive(1, 0, 0, 0, 0, 0, 0, 1, 0);
        tick();
        checks++;
        if (pc !== 32'h55 || parado !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_halt: pc=%h parado=%b expected 55 1", pc, parado);
        end
        @(negedge clock);
        #1;
        reset = 1'b0;
        #1;
        checks++;
        if (pc !== 32'h0 || estado !== 2'd0 || parado !== 1'b0 || instrucoes !== 16'h0) begin
            errors++;
            $display("FAIL async_reset: pc=%h estado=%0d parado=%b instr=%0d expected 0 0 0 0", pc, estado, parado, instrucoes);
        end
        #1;
        reset = 1'b1;
        // Controls asserted during the INICIO cycle must be ignored.
        drive(1, 1, 32'd9, 1, 32'h777, 1, 32'h888, 0, 0);
        tick();
        checks++;
        if (pc !== 32'h0 || estado !== 2'd1 || instrucoes !== 16'h0) begin
            errors++;
            $display("FAIL inicio_ignore: pc=%h estado=%0d instr=%0d expected 0 1 0", pc, estado, instrucoes);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_sequential();
        test_branch();
        test_jump_priority();
        test_halt();
        test_wrap_and_stall();
        test_back_to_back();
        test_saturation();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
